// File: rtl/m9k_arbiter_pkg.sv
// Shared widths, request/response records and arbiter state encoding.
package m9k_arb_pkg;

  localparam int unsigned M9K_ADDR_W = 15;
  localparam int unsigned M9K_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [M9K_ADDR_W-1:0] addr;
    logic [M9K_DATA_W-1:0] wdata;
  } m9k_req_t;

  typedef struct packed {
    logic                  valid;
    logic [M9K_DATA_W-1:0] data;
  } m9k_resp_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/m9k_arbiter_if.sv
// Requester-side handshake bundle for the M9K arbiter.
interface m9k_arbiter_if
  import m9k_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][M9K_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][M9K_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [M9K_DATA_W-1:0]              resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/m9k_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid entry at or after start.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned   pos;
  logic [IW-1:0] p;

  // Scan N positions from start with wrap-around, keep the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    p      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = k + 32'(start);
      if (pos >= N) pos = pos - N;
      p = IW'(pos);
      if (!any && valid[p]) begin
        any       = 1'b1;
        idx       = p;
        onehot[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m9k_arbiter.sv
// Round-robin, burst-limited arbiter in front of a single-port M9K controller.
module m9k_arbiter
  import m9k_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
  m9k_arbiter_if.slave          bus,
  output logic                  mem_w_en,
  output logic [M9K_ADDR_W-1:0] mem_addr,
  output logic [M9K_DATA_W-1:0] mem_data_store,
  input  logic [M9K_DATA_W-1:0] mem_data_load
);

  localparam int unsigned   IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned   CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST    = IW'(NUM_REQ - 1);

  logic [IW-1:0]         owner_q, owner_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [M9K_DATA_W-1:0] resp_data_q, resp_data_d;

  logic [IW-1:0]      start_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               keep_owner;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  m9k_req_t           sel_req;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .valid  (bus.req_valid),
    .start  (start_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grant: stick with the owner inside an unfinished burst, else scan from owner+1.
  // Reset gates the grant so ready and write enable drop asynchronously.
  always_comb begin
    start_ptr  = (owner_q == LAST) ? '0 : owner_q + IW'(1);
    keep_owner = (state_q == ARB_BURST) && bus.req_valid[owner_q] &&
                 (burst_cnt_q < MAX_CNT);
    grant_oh   = '0;
    grant_idx  = owner_q;
    grant_any  = 1'b0;
    if (rst_l) begin
      if (keep_owner) begin
        grant_oh[owner_q] = 1'b1;
        grant_any         = 1'b1;
      end else begin
        grant_oh  = pick_oh;
        grant_idx = pick_idx;
        grant_any = pick_any;
      end
    end
    sel_req.we    = bus.req_we[grant_idx];
    sel_req.addr  = bus.req_addr[grant_idx];
    sel_req.wdata = bus.req_wdata[grant_idx];
  end

  // Memory port mux and requester-facing outputs.
  always_comb begin
    bus.req_ready  = grant_oh;
    mem_w_en       = grant_any & sel_req.we;
    mem_addr       = grant_any ? sel_req.addr  : '0;
    mem_data_store = grant_any ? sel_req.wdata : '0;
    bus.resp_valid = resp_valid_q;
    bus.resp_data  = resp_data_q;
  end

  // Next state: burst bookkeeping and read response capture.
  // A re-selected owner at the burst limit starts a fresh burst at 1.
  always_comb begin
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    state_d      = state_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (grant_any) begin
      state_d = ARB_BURST;
      if ((grant_idx == owner_q) && (state_q == ARB_BURST) && (burst_cnt_q < MAX_CNT)) begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end else begin
        owner_d     = grant_idx;
        burst_cnt_d = CW'(1);
      end
      if (!sel_req.we) begin
        resp_valid_d = grant_oh;
        resp_data_d  = mem_data_load;
      end
    end else begin
      state_d     = ARB_IDLE;
      burst_cnt_d = '0;
    end
  end

  // State registers; reset drops any response in flight.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      state_q      <= ARB_IDLE;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: doc/m9k_arbiter.md
# m9k_arbiter

Round-robin arbiter sharing the single-port `m9k_controller` (15-bit word address, 32-bit data, combinational read, write on clock edge) among `NUM_REQ` requesters (e.g. host loader, tensor compute lanes). Issues at most one memory access per cycle, lets the current owner stream up to `MAX_BURST` back-to-back accesses before rotating, and returns registered read data one cycle after acceptance. Sits between the worker's requesters and the `m9k_controller` instance.

## Interface
- `NUM_REQ`, 2: number of requesters; must be ≥2.
- `MAX_BURST`, 4: maximum consecutive grants to one owner while others wait; must be ≥1.
- `clk` in 1: clock.
- `rst_l` in 1: reset. Asynchronous, active-low.
- `req_valid` in `NUM_REQ`: request pending per requester.
- `req_we` in `NUM_REQ`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQ`×15: word address per requester.
- `req_wdata` in `NUM_REQ`×32: write data per requester.
- `req_ready` out `NUM_REQ`: one-hot grant; access accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid` out `NUM_REQ`: one-cycle pulse, read data for requester i on `resp_data`.
- `resp_data` out 32: registered read data (shared bus).
- `mem_w_en` out 1: to `m9k_controller.w_en`.
- `mem_addr` out 15: to `m9k_controller.addr`.
- `mem_data_store` out 32: to `m9k_controller.data_store`.
- `mem_data_load` in 32: from `m9k_controller.data_load`.

## Operation
- Registered state: `owner` (index, reset 0), `burst_cnt` (width `$clog2(MAX_BURST+1)`, reset 0), `busy` (reset 0; states IDLE = 0, BURST = 1).
- Grant decision, combinational each cycle:
  - In BURST, with `req_valid[owner]` = 1 and `burst_cnt < MAX_BURST`: grant `owner`.
  - Otherwise: grant the first valid requester scanning `owner+1, owner+2, …` with wrap-around, ending at `owner` itself. The owner is the last choice, so it is re-granted only if no one else is valid.
  - No valid requester: no grant.
- On an accepted access by requester g:
  - If g == `owner` and `busy`: `burst_cnt++`.
  - Else: `owner <= g`, `burst_cnt <= 1`.
  - `busy <= 1`.
- Lone requester at `burst_cnt == MAX_BURST`: it is re-selected by the scan. Treat this as a new burst (`burst_cnt <= 1`), so a lone requester streams without stall.
- Cycle with no grant: `busy <= 0`, `burst_cnt <= 0`. `owner` is kept so rotation fairness persists.
- Memory side:
  - While granted: `mem_addr`/`mem_data_store` = granted requester's `req_addr`/`req_wdata`, and `mem_w_en = req_we[g]`.
  - With no grant: `mem_addr = 0`, `mem_data_store = 0`, `mem_w_en = 0`.
- Read accepted: next edge registers `resp_data <= mem_data_load` and `resp_valid <= onehot(g)`.
- Write accepted: no response; `resp_valid` is 0 next cycle. `resp_data` holds its last value when no read completes.
- `req_ready[i]` must not depend on `req_ready`. Requesters may drop `req_valid` at any cycle; an unaccepted request is simply not served.

## Timing
- Grant is same-cycle as valid: zero arbitration latency.
- Throughput: one access per cycle.
- Read latency: accept at edge t, `resp_valid`/`resp_data` valid in cycle t+1.
- Write commits at the accepting edge. A read of the same address accepted in the next cycle returns the new data.
- Worst-case wait for a continuously valid requester: `(NUM_REQ-1)×MAX_BURST` cycles.
- Reset values:
  - `resp_valid` = 0, `resp_data` = 0.
  - `owner` = 0, `burst_cnt` = 0, `busy` = 0.
- While `rst_l` is low: `req_ready` = 0 and `mem_w_en` = 0, forced asynchronously.
- Reset mid-burst or with a read in flight: the pending response is dropped and no `resp_valid` is issued. After release, arbitration starts from requester 1, since the scan begins at `owner+1` with `owner` = 0.

## Structure
- Package `m9k_arb_pkg`:
  - `M9K_ADDR_W = 15`, `M9K_DATA_W = 32`.
  - Typedef `m9k_req_t` struct {`we`, `addr`, `wdata`}.
  - Typedef `m9k_resp_t` struct {`valid`, `data`}.
- Sub-module `rr_picker`: combinational, takes `valid` vector + start pointer, returns one-hot + index of first valid at/after pointer. The arbiter calls it with pointer `owner+1`.
- Expected RTL ~200 lines total.

## Test plan
- Reset with `m9k_controller` image M[0..13] = 1,5,1,2,3,4,5,1,5,6,7,8,9,10. Requester 0 reads addr 1 → `req_ready[0]` same cycle; next cycle `resp_valid` = 2'b01, `resp_data` = 5.
- Requester 1 writes 0xDEADBEEF to addr 20, then reads addr 20 next cycle → `resp_data` = 0xDEADBEEF one cycle after the read grant.
- Both requesters continuously valid with `MAX_BURST` = 4, starting after reset:
  - Grants go R1 ×4, R0 ×4, R1 ×4.
  - No idle cycles.
  - `resp_valid` one-hot matches the grant delayed by 1.
- Only requester 0 valid for 10 cycles → granted all 10 cycles and `req_ready[1]` stays 0. When R1 asserts in cycle 11, it is granted within 4 cycles.
- `rst_l` pulled low between a read grant and its response:
  - `resp_valid` stays 0.
  - `req_ready` and `mem_w_en` are 0 during reset.
  - After release, the first grant goes to R1 when both are valid.
- No requester valid → `mem_w_en` = 0, `mem_addr` = 0, `resp_valid` = 0, `busy` = 0. Memory contents unchanged: M[13] still 10.
